// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO with registered status, occupancy count, thresholds and sticky errors.
// Define SYNC_FIFO_CTL_FWFT_EN for first-word-fall-through read mode; standard registered read otherwise.
module sync_fifo_ctl #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 8,
  parameter int AFULL_TH  = 2**ASIZE - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  if (!(AEMPTY_TH > 0 && AEMPTY_TH < AFULL_TH && AFULL_TH <= 2**ASIZE)) begin : g_param_err
    $error("sync_fifo_ctl: require 0 < AEMPTY_TH < AFULL_TH <= 2**ASIZE");
  end

  localparam logic [ASIZE:0] LP_DEPTH  = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] LP_AFULL  = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] LP_AEMPTY = (ASIZE+1)'(AEMPTY_TH);

  logic [DSIZE-1:0] r_mem [2**ASIZE];
  logic [ASIZE:0]   r_wptr, r_rptr;
  logic             r_full, r_afull, r_empty, r_aempty;
  logic             r_ovf, r_udf;
  logic [DSIZE-1:0] r_rdata;

  logic             w_wr_ok, w_rd_ok;
  logic [ASIZE:0]   w_wptr_nxt, w_rptr_nxt, w_count_nxt;

  // Occupancy is the pointer difference; the extra pointer bit separates full from empty.
  always_comb begin
    w_wr_ok     = winc && !r_full;
    w_rd_ok     = rinc && !r_empty;
    w_wptr_nxt  = r_wptr + (ASIZE+1)'(w_wr_ok);
    w_rptr_nxt  = r_rptr + (ASIZE+1)'(w_rd_ok);
    w_count_nxt = w_wptr_nxt - w_rptr_nxt;
  end

  // Storage is never reset; writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_ok) r_mem[r_wptr[ASIZE-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_empty  <= 1'b1;
      r_aempty <= 1'b1;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_empty  <= (w_count_nxt == '0);
      r_aempty <= (w_count_nxt <= LP_AEMPTY);
      r_full   <= (w_count_nxt == LP_DEPTH);
      r_afull  <= (w_count_nxt >= LP_AFULL);
      if (winc && r_full)  r_ovf <= 1'b1;
      if (rinc && r_empty) r_udf <= 1'b1;
      if (w_rd_ok) r_rdata <= r_mem[r_rptr[ASIZE-1:0]];
    end
  end

`ifdef SYNC_FIFO_CTL_FWFT_EN
  // Head word shown directly; while empty, the last popped word is held.
  assign rdata = r_empty ? r_rdata : r_mem[r_rptr[ASIZE-1:0]];
`else
  assign rdata = r_rdata;
`endif

  assign count         = r_wptr - r_rptr;
  assign wfull         = r_full;
  assign walmost_full  = r_afull;
  assign rempty        = r_empty;
  assign ralmost_empty = r_aempty;
  assign overflow      = r_ovf;
  assign underflow     = r_udf;

endmodule

// File: doc/sync_fifo_ctl.md
# sync_fifo_ctl

Single-clock, parametrised FIFO with registered status, used where producer and consumer share one clock and no clock-domain crossing is needed. It keeps the write/read handshake of the team's asynchronous FIFO (winc/rinc, wfull/rempty). It adds an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. A compile-time option selects first-word-fall-through read mode.

## Interface
- DSIZE, 8: data width in bits.
- ASIZE, 8: address width; depth = 2^ASIZE words.
- AFULL_TH, 2^ASIZE-4: walmost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 4: ralmost_empty asserts when count <= AEMPTY_TH.

- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- winc  in  1  write request.
- wdata  in  DSIZE  write data.
- wfull  out  1  count == 2^ASIZE.
- walmost_full  out  1  count >= AFULL_TH.
- rinc  in  1  read request.
- rdata  out  DSIZE  read data.
- rempty  out  1  count == 0.
- ralmost_empty  out  1  count <= AEMPTY_TH.
- count  out  ASIZE+1  words stored.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

## Operation
- Write accepted iff winc && !wfull: mem[wptr] <= wdata, wptr++.
- Read accepted iff rinc && !rempty: rptr++.
- Pointers are ASIZE+1 bits. Low ASIZE bits address memory. Natural wrap at 2^(ASIZE+1).
- count: +1 on write-only, -1 on read-only, unchanged on both or neither. Never exceeds 2^ASIZE and never goes below 0.
- Flags are registered and derived from next-state count, so they are exact the cycle after the edge.
- Full with winc && rinc: read accepted, write rejected, overflow set, count -> 2^ASIZE-1.
- Empty with winc && rinc (standard mode): write accepted, read rejected, underflow set, count -> 1.
- Rejected write: memory and pointers unchanged. Rejected read: rdata holds its value.
- overflow/underflow: set on any rejected request; cleared only by reset.
- Reset (rst_n low at edge, any time including mid-burst): wptr = rptr = 0, count = 0, rempty = 1, ralmost_empty = 1, wfull = 0, walmost_full = 0 (for AFULL_TH > 0), overflow = underflow = 0, rdata = 0. Memory contents are not cleared. winc/rinc are ignored during that edge.
- Parameter legality: 0 < AEMPTY_TH < AFULL_TH <= 2^ASIZE. Violations are reported by elaboration-time $error.

## Timing
- Standard mode: rdata is registered and updated at the edge that accepts the read (data available one cycle after rinc is sampled). Otherwise it holds.
- Write at edge N into an empty FIFO: rempty low after edge N. The earliest accepted read is at edge N+1, and rdata is valid after N+1.
- Read at edge N from a full FIFO: wfull low after edge N. The earliest accepted write is at edge N+1.
- Sustained one read and one write per cycle is supported at any 0 < count < 2^ASIZE.

## Configuration
- SYNC_FIFO_CTL_FWFT_EN defined: first-word-fall-through. rdata always presents mem[rptr] whenever !rempty, so the head word is visible after the edge that wrote it. rinc acknowledges and pops it, and the next word appears after that edge. With rempty high, rdata holds its last value (0 after reset). Empty + simultaneous winc/rinc behaves as in standard mode (read rejected, underflow set).
- Undefined: standard mode as above. Port list is identical in both builds.

## Test plan
- Reset: hold rst_n low 3 cycles with winc=rinc=1 -> count=0, rempty=1, ralmost_empty=1, wfull=0, overflow=underflow=0, rdata=0.
- Fill/drain, ASIZE=4: write 0x00..0x0F -> wfull=1 after 16th write, walmost_full=1 from count=12, count=16. A 17th write sets overflow=1 with count still 16. Drain 16 reads -> rdata 0x00..0x0F in order, rempty=1, and a further rinc sets underflow=1.
- Concurrent: at count=8, assert winc+rinc 100 cycles with random data -> count stays 8 and all data is ordered. At count=16, winc+rinc -> count=15, overflow=1.
- Wrap: 3 x 2^ASIZE writes interleaved with reads at count ~2 -> no data mismatch and correct flags across pointer wrap.
- Mid-operation reset: at count=10 pulse rst_n low one cycle -> count=0, rempty=1. Next write 0xA5 then read -> rdata=0xA5.
- FWFT build: write 0x3C to an empty FIFO -> rdata=0x3C and rempty=0 after that edge with no rinc. rinc pops it, and rempty=1 next cycle.
